// File: rtl/main_memory_line_responder_pkg.sv
// Shared definitions for the main-memory line responder and the cache stage
// that talks to it: default line geometry, latency and FSM state encoding.
package mem_pkg;

    localparam int DEFAULT_LINE_WIDTH      = 128;
    localparam int DEFAULT_LINE_ADDR_WIDTH = 8;
    localparam int DEFAULT_LATENCY         = 4;
    localparam int CNT_WIDTH               = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_WAIT = WAIT,
        ST_RESP = RESP
    } state_t;

    // Acceptance edge and the RESP cycle account for two of the LATENCY cycles.
    function automatic logic [CNT_WIDTH-1:0] wait_count(input int latency);
        return CNT_WIDTH'(latency - 2);
    endfunction

endpackage

// File: rtl/main_memory_line_responder_line_ram.sv
// Single-port synchronous line array. Contents are never reset; only the
// registered read port is cleared so the responder's rdata has a reset value.
module line_ram #(
    parameter int LINE_WIDTH      = mem_pkg::DEFAULT_LINE_WIDTH,
    parameter int LINE_ADDR_WIDTH = mem_pkg::DEFAULT_LINE_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en_i,
    input  logic                       we_i,
    input  logic [LINE_ADDR_WIDTH-1:0] addr_i,
    input  logic [LINE_WIDTH-1:0]      wdata_i,
    output logic [LINE_WIDTH-1:0]      rdata_o
);

    logic [LINE_WIDTH-1:0] mem_q [0:(1<<LINE_ADDR_WIDTH)-1];
    logic [LINE_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // rdata only moves on a read, so it holds the last read line otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/main_memory_line_responder.sv
// Memory-side responder: accepts one whole-line read or write at a time and
// completes it after a fixed latency with a one-cycle resp_valid pulse.
module main_memory_line_responder
    import mem_pkg::*;
#(
    parameter int LINE_WIDTH      = DEFAULT_LINE_WIDTH,
    parameter int LINE_ADDR_WIDTH = DEFAULT_LINE_ADDR_WIDTH,
    parameter int LATENCY         = DEFAULT_LATENCY
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_is_write,
    input  logic [LINE_ADDR_WIDTH-1:0] req_line_addr,
    input  logic [LINE_WIDTH-1:0]      req_wdata,
    output logic                       resp_valid,
    output logic [LINE_WIDTH-1:0]      resp_rdata,
    output logic                       busy,
    output logic [1:0]                 dbg_state_o
);

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high; req_ready is high only in IDLE, and request
    // inputs are ignored in every other cycle (no queuing).

    state_t                     state_q;
    logic [CNT_WIDTH-1:0]       cnt_q;
    logic                       is_write_q;
    logic [LINE_ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0]      wdata_q;
    logic                       req_ready_q;
    logic                       resp_valid_q;
    logic                       access_en;

    // Reset gating keeps a reset in the last WAIT cycle from committing a write.
    assign access_en = (state_q == ST_WAIT) && (cnt_q == '0) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            is_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        is_write_q  <= req_is_write;
                        addr_q      <= req_line_addr;
                        wdata_q     <= req_wdata;
                        cnt_q       <= wait_count(LATENCY);
                        state_q     <= ST_WAIT;
                        req_ready_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    line_ram #(
        .LINE_WIDTH      (LINE_WIDTH),
        .LINE_ADDR_WIDTH (LINE_ADDR_WIDTH)
    ) u_line_ram (
        .clk     (clk),
        .reset   (reset),
        .en_i    (access_en),
        .we_i    (is_write_q),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (resp_rdata)
    );

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign busy        = !req_ready_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_main_memory_line_responder.sv
// Bench for main_memory_line_responder: directed table, hand-written corner
// sequences and random traffic checked against a timeline reference model.
module tb_main_memory_line_responder;
    import mem_pkg::*;

    localparam int W  = 128;
    localparam int AW = 8;
    localparam int L  = 4;
    localparam int L2 = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0, req_is_write = 1'b0;
    logic [AW-1:0] req_line_addr = '0;
    logic [W-1:0]  req_wdata = '0;
    logic          req_ready, resp_valid, busy;
    logic [W-1:0]  resp_rdata;
    logic [1:0]    dbg_state;

    logic          v2 = 1'b0, wr2 = 1'b0;
    logic [AW-1:0] a2 = '0;
    logic [W-1:0]  d2 = '0;
    logic          ready2, resp2, busy2;
    logic [W-1:0]  rdata2;
    logic [1:0]    st2;

    always #5 clk = ~clk;

    main_memory_line_responder #(.LINE_WIDTH(W), .LINE_ADDR_WIDTH(AW), .LATENCY(L)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_is_write(req_is_write), .req_line_addr(req_line_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy), .dbg_state_o(dbg_state)
    );

    main_memory_line_responder #(.LINE_WIDTH(W), .LINE_ADDR_WIDTH(AW), .LATENCY(L2)) dut2 (
        .clk(clk), .reset(reset), .req_valid(v2), .req_ready(ready2),
        .req_is_write(wr2), .req_line_addr(a2), .req_wdata(d2),
        .resp_valid(resp2), .resp_rdata(rdata2), .busy(busy2), .dbg_state_o(st2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: a timeline of when the responder is ready and when
    // its response is due, plus an associative array of committed lines.
    longint       cyc = 0;
    longint       ready_at = 0;
    longint       resp_at = -1;
    bit           known = 1'b0;
    bit           pend_wr;
    logic [AW-1:0] pend_addr;
    logic [W-1:0] pend_data;
    logic [W-1:0] exp_rdata = '0;
    logic [W-1:0] model_mem [int];
    bit           m_ready, m_resp;
    logic         s_ready, s_resp;
    logic [W-1:0] s_rdata;

    task automatic step(input bit rst, input bit v, input bit wr,
                        input logic [AW-1:0] a, input logic [W-1:0] d);
        logic [1:0] e_st;
        @(negedge clk);
        s_ready = req_ready;
        s_resp  = resp_valid;
        s_rdata = resp_rdata;
        m_ready = (cyc >= ready_at);
        m_resp  = (cyc == resp_at);
        if (m_resp) begin
            if (pend_wr) model_mem[int'(pend_addr)] = pend_data;
            else         exp_rdata = model_mem[int'(pend_addr)];
        end
        e_st = m_ready ? IDLE : (m_resp ? RESP : WAIT);
        if (known) begin
            check($sformatf("req_ready@%0d", cyc), W'(req_ready), W'(m_ready));
            check($sformatf("resp_valid@%0d", cyc), W'(resp_valid), W'(m_resp));
            check($sformatf("busy@%0d", cyc), W'(busy), W'(!m_ready));
            check($sformatf("resp_rdata@%0d", cyc), resp_rdata, exp_rdata);
            check($sformatf("state@%0d", cyc), W'(dbg_state), W'(e_st));
        end
        reset         = rst;
        req_valid     = v;
        req_is_write  = wr;
        req_line_addr = a;
        req_wdata     = d;
        if (rst) begin
            known     = 1'b1;
            ready_at  = cyc + 1;
            resp_at   = -1;
            exp_rdata = '0;
        end else if (m_ready && v) begin
            pend_wr   = wr;
            pend_addr = a;
            pend_data = d;
            resp_at   = cyc + L;
            ready_at  = cyc + L + 1;
        end
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wait_ready();
        int k = 0;
        while (cyc < ready_at && k < 50) begin
            idle();
            k++;
        end
    endtask

    task automatic send(input bit wr, input logic [AW-1:0] a, input logic [W-1:0] d);
        wait_ready();
        step(1'b0, 1'b1, wr, a, d);
    endtask

    // Read line a and check the data seen in the response cycle.
    task automatic read_check(input string name, input logic [AW-1:0] a, input logic [W-1:0] exp);
        send(1'b0, a, '0);
        for (int i = 0; i < L; i++) idle();
        check({name, "_valid"}, W'(s_resp), W'(1));
        check({name, "_data"}, s_rdata, exp);
    endtask

    typedef struct {
        bit            v;
        bit            wr;
        logic [AW-1:0] a;
        logic [W-1:0]  d;
        bit            e_ready;
        bit            e_resp;
        logic [W-1:0]  e_rdata;
    } vec_t;

    localparam logic [W-1:0] DB = 128'hCAFEF00D_12345678_0BADC0DE_DEADBEEF;
    vec_t tbl [11];

    initial begin : main
        logic [W-1:0] x, b1, b2, saved;
        bit           rst, v, wr;
        logic [AW-1:0] a;

        tbl[0]  = '{1, 1, 8'h05, DB,            1, 0, '0};
        tbl[1]  = '{0, 0, 8'h00, '0,            0, 0, '0};
        tbl[2]  = '{1, 1, 8'h05, 128'h1234,     0, 0, '0};
        tbl[3]  = '{0, 0, 8'h00, '0,            0, 0, '0};
        tbl[4]  = '{0, 0, 8'h00, '0,            0, 1, '0};
        tbl[5]  = '{1, 0, 8'h05, '0,            1, 0, '0};
        tbl[6]  = '{0, 0, 8'h00, '0,            0, 0, '0};
        tbl[7]  = '{0, 0, 8'h00, '0,            0, 0, '0};
        tbl[8]  = '{0, 0, 8'h00, '0,            0, 0, '0};
        tbl[9]  = '{0, 0, 8'h00, '0,            0, 1, DB};
        tbl[10] = '{0, 0, 8'h00, '0,            1, 0, DB};

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, '0);
        idle();
        check("reset_ready", W'(s_ready), W'(1));
        check("reset_resp_valid", W'(s_resp), W'(0));
        check("reset_rdata", s_rdata, '0);
        idle();

        // Write 0x05 then read it back, with a busy-time write that must be ignored.
        for (int i = 0; i < 11; i++) begin
            step(1'b0, tbl[i].v, tbl[i].wr, tbl[i].a, tbl[i].d);
            check($sformatf("tbl%0d_ready", i), W'(s_ready), W'(tbl[i].e_ready));
            check($sformatf("tbl%0d_resp", i), W'(s_resp), W'(tbl[i].e_resp));
            check($sformatf("tbl%0d_rdata", i), s_rdata, tbl[i].e_rdata);
        end

        // Back-to-back with req_valid held high.
        b1 = {$urandom, $urandom, $urandom, $urandom};
        b2 = {$urandom, $urandom, $urandom, $urandom};
        wait_ready();
        step(1'b0, 1'b1, 1'b1, 8'h01, b1);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b1, 1'b1, 8'h02, b2 ^ W'(i));
            if (i == 4) check("b2b_busy_T+4", W'(s_ready), W'(0));
            if (i == 5) check("b2b_accept_T+5", W'(s_ready), W'(1));
        end
        idle();
        read_check("b2b_rd01", 8'h01, b1);
        read_check("b2b_rd02", 8'h02, b2 ^ W'(5));

        // Reset during WAIT drops the pending write to 0x10.
        send(1'b1, 8'h10, '0);
        send(1'b1, 8'h10, 128'hAA);
        idle();
        step(1'b1, 1'b0, 1'b0, '0, '0);
        idle();
        check("rst_mid_ready", W'(s_ready), W'(1));
        check("rst_mid_resp", W'(s_resp), W'(0));
        for (int i = 0; i < 6; i++) idle();
        read_check("rst_mid_rd10", 8'h10, '0);

        // Write then read the same line in the first ready cycle.
        x = {$urandom, $urandom, $urandom, $urandom};
        saved = exp_rdata;
        send(1'b1, 8'h20, x);
        for (int i = 0; i < L; i++) idle();
        check("wr_resp_valid", W'(s_resp), W'(1));
        check("wr_resp_rdata_held", s_rdata, saved);
        read_check("wr_then_rd", 8'h20, x);

        // Random traffic, including requests while busy and occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 40) == 0);
            v   = $urandom_range(0, 1);
            wr  = $urandom_range(0, 1);
            a   = AW'($urandom_range(0, 15));
            if (!wr && !model_mem.exists(int'(a))) wr = 1'b1;
            step(rst, v, wr, a, {$urandom, $urandom, $urandom, $urandom});
        end
        wait_ready();
        idle();

        // LATENCY=2 instance.
        x = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        check("l2_idle_ready", W'(ready2), W'(1));
        v2 = 1'b1; wr2 = 1'b1; a2 = 8'h03; d2 = x;
        @(negedge clk);
        v2 = 1'b0;
        check("l2_wr_T+1_ready", W'(ready2), W'(0));
        check("l2_wr_T+1_resp", W'(resp2), W'(0));
        @(negedge clk);
        check("l2_wr_T+2_resp", W'(resp2), W'(1));
        check("l2_wr_T+2_ready", W'(ready2), W'(0));
        @(negedge clk);
        check("l2_wr_T+3_ready", W'(ready2), W'(1));
        check("l2_wr_T+3_resp", W'(resp2), W'(0));
        v2 = 1'b1; wr2 = 1'b0; a2 = 8'h03; d2 = '0;
        @(negedge clk);
        v2 = 1'b0;
        check("l2_rd_T+1_ready", W'(ready2), W'(0));
        @(negedge clk);
        check("l2_rd_T+2_resp", W'(resp2), W'(1));
        check("l2_rd_T+2_rdata", rdata2, x);
        @(negedge clk);
        check("l2_rd_T+3_ready", W'(ready2), W'(1));
        check("l2_rd_T+3_rdata", rdata2, x);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

endmodule
